// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: A - B - Bin, LSB first, one bit per clock, SIZE clocks per operation.
// Optional macro SERSUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic            Bin,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] D,
  output logic            Bout,
`ifdef SERSUB_OVF_EN
  output logic            ovf,
`endif
  output logic [1:0]      fsm_state
);

  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Handshake: start is sampled only in IDLE; done is a one-cycle pulse after
  // which D/Bout stay valid until the next accepted start. No backpressure.
  state_t          state, state_next;
  logic [SIZE-1:0] a_reg, b_reg, d_reg;
  logic [CW-1:0]   cnt;
  logic            br, bout_reg;
  logic            d_bit, br_next, last_bit;

  assign d_bit    = a_reg[0] ^ b_reg[0] ^ br;
  assign br_next  = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & br);
  assign last_bit = (cnt == CW'(SIZE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      d_reg    <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      bout_reg <= 1'b0;
    end else if (state == IDLE && start) begin
      a_reg <= A;
      b_reg <= B;
      br    <= Bin;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      d_reg <= {d_bit, d_reg[SIZE-1:1]};
      a_reg <= a_reg >> 1;
      b_reg <= b_reg >> 1;
      br    <= br_next;
      cnt   <= cnt + CW'(1);
      if (last_bit) bout_reg <= br_next;
    end
  end

`ifdef SERSUB_OVF_EN
  logic ovf_reg;
  // On the last bit a_reg[0]/b_reg[0] hold the operand sign bits and d_bit is the result sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_reg <= 1'b0;
    else if (state == SHIFT && last_bit)
      ovf_reg <= (a_reg[0] != b_reg[0]) && (d_bit != a_reg[0]);
  end
  assign ovf = ovf_reg;
`endif

  assign D         = d_reg;
  assign Bout      = bout_reg;
  assign fsm_state = state;

endmodule
